// File: rtl/complex_mag_sq_avg.sv
// complex_mag_sq_avg: 3-stage |x|^2 = i^2 + q^2 power estimator on a strobed
// complex sample stream, with an optional power-of-two moving average of |x|^2.
// Build macro MAG_SQ_AVG_EN: when defined, the moving-average stage (ring
// buffer, running sum, fill counter) is built; when undefined the avg_* outputs
// are tied to zero and the mag_sq path is unchanged.
module complex_mag_sq_avg #(
    parameter int IN_WIDTH = 16,
    parameter int LOG2_WIN = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [IN_WIDTH-1:0]   i,
    input  logic signed [IN_WIDTH-1:0]   q,
    input  logic                         input_strobe,
    output logic        [2*IN_WIDTH-1:0] mag_sq,
    output logic                         mag_sq_strobe,
    output logic        [2*IN_WIDTH-1:0] avg_power,
    output logic                         avg_strobe,
    output logic                         avg_full
);

    localparam int PW = 2 * IN_WIDTH;

    logic signed [IN_WIDTH-1:0] i_p1_q;
    logic signed [IN_WIDTH-1:0] q_p1_q;
    logic                       vld_p1_q;
    logic signed [PW-1:0]       ii_p2_q;
    logic signed [PW-1:0]       qq_p2_q;
    logic                       vld_p2_q;
    logic        [PW-1:0]       mag_p3_q;
    logic                       vld_p3_q;

    logic signed [PW-1:0]       ii_d;
    logic signed [PW-1:0]       qq_d;
    logic        [PW-1:0]       mag_d;

    // Operands are sign-extended to the full product width so the square of the
    // most negative input (2^(2*IN_WIDTH-2)) is represented exactly.
    assign ii_d = PW'(i_p1_q) * PW'(i_p1_q);
    assign qq_d = PW'(q_p1_q) * PW'(q_p1_q);

    // Both squares are non-negative and at most 2^(PW-2), so their sum fits in
    // PW unsigned bits without saturation.
    assign mag_d = $unsigned(ii_p2_q) + $unsigned(qq_p2_q);

    // Datapath registers for stages 1 and 2; they carry no reset since the
    // valid bits decide whether their contents mean anything.
    always_ff @(posedge clock) begin
        if (enable) begin
            // ---- stage 1: capture raw sample
            i_p1_q  <= i;
            q_p1_q  <= q;
            // ---- stage 2: squares
            ii_p2_q <= ii_d;
            qq_p2_q <= qq_d;
        end
    end

    // Valid pipeline plus the stage-3 result, which resets to zero and holds
    // its last value between samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            mag_p3_q <= '0;
        end else if (enable) begin
            vld_p1_q <= input_strobe;
            vld_p2_q <= vld_p1_q;
            // ---- stage 3: sum of squares
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                mag_p3_q <= mag_d;
            end
        end
    end

    assign mag_sq        = mag_p3_q;
    assign mag_sq_strobe = vld_p3_q & enable;

`ifdef MAG_SQ_AVG_EN

    localparam int SW = PW + LOG2_WIN;
    localparam int N  = 1 << LOG2_WIN;

    // Average is a plain right shift: truncation toward zero of a non-negative sum.
    function automatic logic [PW-1:0] window_mean(input logic [SW-1:0] s);
        window_mean = PW'(s >> LOG2_WIN);
    endfunction

    logic [PW-1:0]       ring_q [N];
    logic [LOG2_WIN-1:0] wr_ptr_q;
    logic [LOG2_WIN:0]   fill_q;
    logic [SW-1:0]       sum_q;
    logic                avg_vld_q;

    logic                take;
    logic                full;
    logic [PW-1:0]       oldest;
    logic [SW-1:0]       sum_d;
    logic [LOG2_WIN:0]   fill_d;

    assign take   = enable & vld_p3_q;
    assign full   = (fill_q == (LOG2_WIN + 1)'(N));
    // Until the window has filled, the slot being overwritten holds stale data
    // (possibly from before a reset) and must not be subtracted.
    assign oldest = full ? ring_q[wr_ptr_q] : '0;
    assign sum_d  = sum_q + SW'(mag_p3_q) - SW'(oldest);
    assign fill_d = full ? fill_q : fill_q + 1'b1;

    // Ring buffer contents: written on each accepted sample, never reset.
    always_ff @(posedge clock) begin
        if (!reset && take) begin
            ring_q[wr_ptr_q] <= mag_p3_q;
        end
    end

    // Averager control: write pointer, saturating fill count, running sum, strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            avg_vld_q <= 1'b0;
        end else if (enable) begin
            // ---- stage 4: running window sum
            avg_vld_q <= vld_p3_q;
            if (vld_p3_q) begin
                sum_q    <= sum_d;
                wr_ptr_q <= wr_ptr_q + 1'b1;
                fill_q   <= fill_d;
            end
        end
    end

    assign avg_power  = window_mean(sum_q);
    assign avg_strobe = avg_vld_q & enable;
    assign avg_full   = full;

`else

    assign avg_power  = '0;
    assign avg_strobe = 1'b0;
    assign avg_full   = 1'b0;

`endif

endmodule
